// File: rtl/hazard_stall_unit_pkg.sv
// Shared types for the hazard/stall unit: FSM state encoding, pipeline
// control bundle and helpers that build the standard control patterns.
package hazard_stall_unit_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_ERROR    = 2'd2
    } state_e;

    // Canonical bubble instruction (addi x0, x0, 0) loaded by flushes.
    localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;
    localparam int          REG_ADDR_W = 5;

    typedef struct packed {
        logic pc_stall;
        logic ifid_stall;
        logic ifid_flush;
        logic idex_flush;
        logic idex_stall;
        logic exmem_stall;
        logic memwb_bubble;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = '0;

    // Whole front end held while memory is busy; MEM/WB gets a bubble so
    // the stalled access is not retired twice.
    function automatic ctrl_t ctrl_freeze();
        ctrl_t c;
        c              = CTRL_IDLE;
        c.pc_stall     = 1'b1;
        c.ifid_stall   = 1'b1;
        c.idex_stall   = 1'b1;
        c.exmem_stall  = 1'b1;
        c.memwb_bubble = 1'b1;
        return c;
    endfunction

    // Wrong-path instructions in IF/ID and ID/EX are squashed; PC keeps
    // moving so the redirect target is fetched next.
    function automatic ctrl_t ctrl_redirect();
        ctrl_t c;
        c            = CTRL_IDLE;
        c.ifid_flush = 1'b1;
        c.idex_flush = 1'b1;
        return c;
    endfunction

    // One-cycle load-use bubble: hold the consumer in ID, insert a NOP into EX.
    function automatic ctrl_t ctrl_load_use();
        ctrl_t c;
        c            = CTRL_IDLE;
        c.pc_stall   = 1'b1;
        c.ifid_stall = 1'b1;
        c.idex_flush = 1'b1;
        return c;
    endfunction

endpackage

// File: rtl/hazard_stall_unit_if.sv
// Pipeline-facing bundle of the hazard/stall unit. The pipeline (master)
// supplies the hazard observations; the unit (slave) returns controls.
interface hazard_stall_unit_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       i_ifid_rs1;
    logic [4:0]       i_ifid_rs2;
    logic             i_ifid_uses_rs1;
    logic             i_ifid_uses_rs2;
    logic [4:0]       i_idex_rd;
    logic             i_idex_memRead;
    logic             i_ex_redirect;
    logic             i_dmem_req;
    logic             i_dmem_ready;

    logic             o_pc_stall;
    logic             o_ifid_stall;
    logic             o_ifid_flush;
    logic             o_idex_flush;
    logic             o_idex_stall;
    logic             o_exmem_stall;
    logic             o_memwb_bubble;
    logic             o_mem_timeout;
    logic [CNT_W-1:0] o_stall_cycles;

    modport master (
        output i_ifid_rs1, i_ifid_rs2, i_ifid_uses_rs1, i_ifid_uses_rs2,
               i_idex_rd, i_idex_memRead, i_ex_redirect, i_dmem_req, i_dmem_ready,
        input  o_pc_stall, o_ifid_stall, o_ifid_flush, o_idex_flush, o_idex_stall,
               o_exmem_stall, o_memwb_bubble, o_mem_timeout, o_stall_cycles
    );

    modport slave (
        input  i_ifid_rs1, i_ifid_rs2, i_ifid_uses_rs1, i_ifid_uses_rs2,
               i_idex_rd, i_idex_memRead, i_ex_redirect, i_dmem_req, i_dmem_ready,
        output o_pc_stall, o_ifid_stall, o_ifid_flush, o_idex_flush, o_idex_stall,
               o_exmem_stall, o_memwb_bubble, o_mem_timeout, o_stall_cycles
    );

endinterface

// File: rtl/hazard_stall_unit_load_use_detect.sv
// Combinational load-use detector: the instruction in ID reads a register
// that the load currently in EX has not yet fetched from memory.
module load_use_detect
    import hazard_stall_unit_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] i_ifid_rs1,
    input  logic [REG_ADDR_W-1:0] i_ifid_rs2,
    input  logic                  i_ifid_uses_rs1,
    input  logic                  i_ifid_uses_rs2,
    input  logic [REG_ADDR_W-1:0] i_idex_rd,
    input  logic                  i_idex_memRead,
    output logic                  o_lu
);

    logic [REG_ADDR_W-1:0] src_addr [2];
    logic                  src_used [2];
    logic [1:0]            src_hit;

    assign src_addr[0] = i_ifid_rs1;
    assign src_addr[1] = i_ifid_rs2;
    assign src_used[0] = i_ifid_uses_rs1;
    assign src_used[1] = i_ifid_uses_rs2;

    // A source only counts when the ID instruction really reads it; the
    // register field of an unused operand may hold immediate bits.
    for (genvar gi = 0; gi < 2; gi++) begin : g_src
        assign src_hit[gi] = src_used[gi] && (src_addr[gi] == i_idex_rd);
    end

    // x0 is hard-wired to zero, so a load targeting it never creates a hazard.
    assign o_lu = i_idex_memRead && (i_idex_rd != '0) && (|src_hit);

endmodule

// File: rtl/hazard_stall_unit.sv
// Stall/flush/bubble generator for hazards that forwarding cannot cover:
// load-use, EX redirects and multi-cycle data-memory accesses. A small FSM
// tracks memory waits with a timeout watchdog; a saturating counter records
// the number of cycles the PC was held.
module hazard_stall_unit
    import hazard_stall_unit_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255,
    parameter int TO_W        = 8,
    parameter int CNT_W       = 32
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    hazard_stall_unit_if.slave bus
);

    localparam logic [TO_W-1:0] TIMEOUT_VAL = TO_W'(MEM_TIMEOUT);
    localparam logic [TO_W-1:0] WAIT_FIRST  = TO_W'(1);

    state_e            state_q, state_d;
    logic [TO_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic [TO_W-1:0]   wait_cnt_inc;
    logic              timeout_q;
    logic [CNT_W-1:0]  stall_cnt_q;
    logic              lu;
    logic              mem_busy;
    ctrl_t             ctrl_raw;
    ctrl_t             ctrl;

    load_use_detect u_lu (
        .i_ifid_rs1      (bus.i_ifid_rs1),
        .i_ifid_rs2      (bus.i_ifid_rs2),
        .i_ifid_uses_rs1 (bus.i_ifid_uses_rs1),
        .i_ifid_uses_rs2 (bus.i_ifid_uses_rs2),
        .i_idex_rd       (bus.i_idex_rd),
        .i_idex_memRead  (bus.i_idex_memRead),
        .o_lu            (lu)
    );

    assign mem_busy     = bus.i_dmem_req && !bus.i_dmem_ready;
    assign wait_cnt_inc = wait_cnt_q + WAIT_FIRST;

    // Next-state and control decode; the memory wait dominates everything
    // because the whole pipeline must freeze behind the stalled access.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        ctrl_raw   = CTRL_IDLE;
        unique case (state_q)
            ST_RUN: begin
                if (mem_busy) begin
                    ctrl_raw   = ctrl_freeze();
                    wait_cnt_d = WAIT_FIRST;
                    state_d    = (WAIT_FIRST == TIMEOUT_VAL) ? ST_ERROR : ST_MEM_WAIT;
                end else if (bus.i_ex_redirect) begin
                    // ID holds a wrong-path instruction, so any load-use on it is moot.
                    ctrl_raw = ctrl_redirect();
                end else if (lu) begin
                    ctrl_raw = ctrl_load_use();
                end
            end
            ST_MEM_WAIT: begin
                // EX is frozen, so redirect/load-use inputs remain valid and
                // are handled once the access completes.
                ctrl_raw = ctrl_freeze();
                if (bus.i_dmem_ready) begin
                    state_d    = ST_RUN;
                    wait_cnt_d = '0;
                end else begin
                    wait_cnt_d = wait_cnt_inc;
                    if (wait_cnt_inc == TIMEOUT_VAL) begin
                        state_d = ST_ERROR;
                    end
                end
            end
            ST_ERROR: begin
                ctrl_raw = ctrl_freeze();
            end
            default: begin
                state_d    = ST_RUN;
                wait_cnt_d = '0;
            end
        endcase
    end

    // Controls are forced inactive while reset is held.
    assign ctrl = i_rst_n ? ctrl_raw : CTRL_IDLE;

    // FSM state and wait-cycle counter.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q    <= ST_RUN;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Sticky watchdog flag: once the memory has hung only reset clears it.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            timeout_q <= 1'b0;
        end else if (state_d == ST_ERROR) begin
            timeout_q <= 1'b1;
        end
    end

    // Saturating count of PC-stall cycles for performance monitoring.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            stall_cnt_q <= '0;
        end else if (ctrl.pc_stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
        end
    end

    assign bus.o_pc_stall     = ctrl.pc_stall;
    assign bus.o_ifid_stall   = ctrl.ifid_stall;
    assign bus.o_ifid_flush   = ctrl.ifid_flush;
    assign bus.o_idex_flush   = ctrl.idex_flush;
    assign bus.o_idex_stall   = ctrl.idex_stall;
    assign bus.o_exmem_stall  = ctrl.exmem_stall;
    assign bus.o_memwb_bubble = ctrl.memwb_bubble;
    assign bus.o_mem_timeout  = i_rst_n && timeout_q;
    assign bus.o_stall_cycles = stall_cnt_q;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Scoreboard bench for hazard_stall_unit: each driven cycle pushes the
// reference model's expected response; a negedge monitor pops and compares.
module tb_hazard_stall_unit;

    localparam int MEM_TIMEOUT = 4;
    localparam int TO_W        = 3;
    localparam int CNT_W       = 3;
    localparam int CNT_MAX     = (1 << CNT_W) - 1;

    // Control vector order: pc_stall, ifid_stall, ifid_flush, idex_flush,
    // idex_stall, exmem_stall, memwb_bubble
    localparam logic [6:0] C_NONE   = 7'b000_0000;
    localparam logic [6:0] C_FREEZE = 7'b110_0111;
    localparam logic [6:0] C_REDIR  = 7'b001_1000;
    localparam logic [6:0] C_LU     = 7'b110_1000;

    typedef struct {
        logic [6:0]       ctrl;
        logic             to;
        logic [CNT_W-1:0] cnt;
        int               id;
    } exp_t;

    logic i_clk;
    logic i_rst_n;

    hazard_stall_unit_if #(.CNT_W(CNT_W)) hs_if ();

    hazard_stall_unit #(
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .TO_W        (TO_W),
        .CNT_W       (CNT_W)
    ) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .bus     (hs_if)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   txn_id   = 0;

    // Reference model state: memory wait in progress, watchdog tripped,
    // consecutive wait cycles so far, stalled cycles so far.
    bit m_wait    = 0;
    bit m_err     = 0;
    int m_waited  = 0;
    int m_stalls  = 0;

    task automatic chk(input string name, input int act, input int req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end else begin
            $display("ok   %s: %0d", name, act);
        end
    endtask

    // Drive one cycle, predict its response and advance the model.
    task automatic drive(input bit rst_n, input logic [4:0] rs1, input logic [4:0] rs2,
                         input bit u1, input bit u2, input logic [4:0] rd, input bit mr,
                         input bit redir, input bit req, input bit rdy);
        exp_t e;
        bit   lu;
        @(posedge i_clk);
        #1;
        i_rst_n               = rst_n;
        hs_if.i_ifid_rs1      = rs1;
        hs_if.i_ifid_rs2      = rs2;
        hs_if.i_ifid_uses_rs1 = u1;
        hs_if.i_ifid_uses_rs2 = u2;
        hs_if.i_idex_rd       = rd;
        hs_if.i_idex_memRead  = mr;
        hs_if.i_ex_redirect   = redir;
        hs_if.i_dmem_req      = req;
        hs_if.i_dmem_ready    = rdy;

        lu = mr && (rd != 0) && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
        if (!rst_n)                              e.ctrl = C_NONE;
        else if (m_wait || m_err || (req && !rdy)) e.ctrl = C_FREEZE;
        else if (redir)                          e.ctrl = C_REDIR;
        else if (lu)                             e.ctrl = C_LU;
        else                                     e.ctrl = C_NONE;
        e.to  = rst_n && m_err;
        e.cnt = m_stalls[CNT_W-1:0];
        e.id  = txn_id++;
        exp_q.push_back(e);

        if (!rst_n) begin
            m_wait = 0; m_err = 0; m_waited = 0; m_stalls = 0;
        end else begin
            if (e.ctrl[6] && m_stalls < CNT_MAX) m_stalls++;
            if (m_err) begin
                // frozen until reset
            end else if (m_wait) begin
                if (rdy) m_wait = 0;
                else begin
                    m_waited++;
                    if (m_waited >= MEM_TIMEOUT) begin m_err = 1; m_wait = 0; end
                end
            end else if (req && !rdy) begin
                m_waited = 1;
                if (m_waited >= MEM_TIMEOUT) m_err = 1;
                else m_wait = 1;
            end
        end
    endtask

    task automatic idle(input bit rst_n);
        drive(rst_n, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0);
    endtask

    // Monitor: compare every presented cycle against the queued expectation.
    always @(negedge i_clk) begin
        if (exp_q.size() > 0) begin
            exp_t       e;
            logic [6:0] act;
            e   = exp_q.pop_front();
            act = {hs_if.o_pc_stall, hs_if.o_ifid_stall, hs_if.o_ifid_flush,
                   hs_if.o_idex_flush, hs_if.o_idex_stall, hs_if.o_exmem_stall,
                   hs_if.o_memwb_bubble};
            n_checks += 3;
            if (act !== e.ctrl) begin
                n_fail++;
                $display("FAIL ctrl txn %0d: got %b expected %b", e.id, act, e.ctrl);
            end
            if (hs_if.o_mem_timeout !== e.to) begin
                n_fail++;
                $display("FAIL timeout txn %0d: got %b expected %b", e.id, hs_if.o_mem_timeout, e.to);
            end
            if (hs_if.o_stall_cycles !== e.cnt) begin
                n_fail++;
                $display("FAIL stall_cycles txn %0d: got %0d expected %0d", e.id, hs_if.o_stall_cycles, e.cnt);
            end
            $display("txn %0d ctrl=%b to=%b cnt=%0d", e.id, act, hs_if.o_mem_timeout, hs_if.o_stall_cycles);
        end
    end

    initial begin
        i_rst_n = 1'b0;
        hs_if.i_ifid_rs1 = '0; hs_if.i_ifid_rs2 = '0;
        hs_if.i_ifid_uses_rs1 = 0; hs_if.i_ifid_uses_rs2 = 0;
        hs_if.i_idex_rd = '0; hs_if.i_idex_memRead = 0;
        hs_if.i_ex_redirect = 0; hs_if.i_dmem_req = 0; hs_if.i_dmem_ready = 0;

        idle(0);
        @(negedge i_clk);
        chk("reset_pc_stall", int'(hs_if.o_pc_stall), 0);
        idle(1);
        @(negedge i_clk);
        chk("reset_stall_cycles", int'(hs_if.o_stall_cycles), 0);

        // Load-use: lw x5 in EX, add x6,x5,x1 in ID
        drive(1, 5'd5, 5'd1, 1, 1, 5'd5, 1, 0, 0, 0);
        @(negedge i_clk);
        chk("lu_pc_stall", int'(hs_if.o_pc_stall), 1);
        chk("lu_idex_flush", int'(hs_if.o_idex_flush), 1);
        drive(1, 5'd5, 5'd1, 1, 1, 5'd0, 0, 0, 0, 0);
        @(negedge i_clk);
        chk("lu_released", int'(hs_if.o_pc_stall), 0);

        // No hazard: rd=x0, and unused matching source
        drive(1, 5'd0, 5'd3, 1, 1, 5'd0, 1, 0, 0, 0);
        @(negedge i_clk);
        chk("lu_x0", int'(hs_if.o_pc_stall), 0);
        drive(1, 5'd7, 5'd2, 0, 1, 5'd7, 1, 0, 0, 0);
        @(negedge i_clk);
        chk("lu_unused_rs1", int'(hs_if.o_pc_stall), 0);

        // Redirect with load-use: redirect wins
        drive(1, 5'd9, 5'd9, 1, 1, 5'd9, 1, 1, 0, 0);
        @(negedge i_clk);
        chk("redir_ifid_flush", int'(hs_if.o_ifid_flush), 1);
        chk("redir_pc_stall", int'(hs_if.o_pc_stall), 0);

        // Memory wait: 3 not-ready cycles then ready
        idle(0);
        repeat (3) drive(1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 0);
        drive(1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 1);
        @(negedge i_clk);
        chk("wait_ready_cycle_stall", int'(hs_if.o_exmem_stall), 1);
        idle(1);
        @(negedge i_clk);
        chk("wait_exit_pc_stall", int'(hs_if.o_pc_stall), 0);
        chk("wait_stall_cycles", int'(hs_if.o_stall_cycles), 4);

        // Watchdog: ready never arrives
        idle(0);
        repeat (4) drive(1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 0);
        idle(1);
        @(negedge i_clk);
        chk("timeout_set", int'(hs_if.o_mem_timeout), 1);
        drive(1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 1);
        @(negedge i_clk);
        chk("timeout_sticky", int'(hs_if.o_mem_timeout), 1);
        chk("error_frozen", int'(hs_if.o_pc_stall), 1);
        idle(0);
        idle(1);
        @(negedge i_clk);
        chk("timeout_cleared", int'(hs_if.o_mem_timeout), 0);
        chk("run_after_reset", int'(hs_if.o_pc_stall), 0);

        // Saturation: 10 stalled cycles with a 3-bit counter
        idle(0);
        repeat (10) drive(1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 0);
        idle(1);
        @(negedge i_clk);
        chk("stall_cnt_saturate", int'(hs_if.o_stall_cycles), CNT_MAX);
        idle(0);

        // Randomised traffic
        for (int n = 0; n < 3000; n++) begin
            drive(($urandom_range(0, 39) != 0),
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                  5'($urandom_range(0, 3)), $urandom_range(0, 2) == 0,
                  $urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 1) == 1);
        end
        idle(1);

        for (int w = 0; w < 20 && exp_q.size() > 0; w++) @(posedge i_clk);
        @(negedge i_clk);
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d responses outstanding, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "time limit");
    end

endmodule
